// File: rtl/pe_array_pkg.sv
// Shared types and constants for the PE-array gather-output network.
package pe_array_pkg;

  localparam int ROW_TAG_W = 4;
  localparam int COL_TAG_W = 4;
  localparam int LEN_W     = 4;
  localparam int ROWS      = 12;
  localparam int COLS      = 14;
  localparam int N         = ROWS * COLS;

  // All-ones in a tag dimension selects every PE in that dimension.
  localparam logic [ROW_TAG_W-1:0] ROW_ANY = '1;
  localparam logic [COL_TAG_W-1:0] COL_ANY = '1;

  // One queued gather request; len holds the burst length minus one.
  typedef struct packed {
    logic [ROW_TAG_W-1:0] row;
    logic [COL_TAG_W-1:0] col;
    logic [LEN_W-1:0]     len;
  } tag_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Power-of-two depth.
// A write while full is accepted only when a read happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // The head reads as zero while empty so nothing stale leaks out after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array write.
  // NOTE: the array is deliberately not reset; occupancy gates every read, so its contents never matter while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/gon_rr_collector.sv
// Gather-output network: tag-selected round-robin collection of PE opsums
// into a single output FIFO, with a scan-loaded {row,col} ID per PE.
module gon_rr_collector
  import pe_array_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ROW_TAG_WIDTH   = ROW_TAG_W,  // must match the tag_t field widths
  parameter int COL_TAG_WIDTH   = COL_TAG_W,
  parameter int LEN_WIDTH       = LEN_W,
  parameter int NUM_OF_ROWS     = ROWS,
  parameter int NUM_OF_COLS     = COLS,
  parameter int DATA_FIFO_DEPTH = 16,
  parameter int TAGS_FIFO_DEPTH = 16
) (
  input  logic                                                      clk,
  input  logic                                                      reset,
  input  logic [ROW_TAG_WIDTH-1:0]                                  row_tag,
  input  logic [COL_TAG_WIDTH-1:0]                                  col_tag,
  input  logic [LEN_WIDTH-1:0]                                      len_tag,
  input  logic                                                      tags_wr_en,
  output logic                                                      tags_full,
  input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0]                   ready_in,
  input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][DATA_WIDTH-1:0]   data_in,
  output logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0]                   enable_out,
  output logic [DATA_WIDTH-1:0]                                     data_out,
  input  logic                                                      data_rd_en,
  output logic                                                      data_empty,
  input  logic                                                      se_id,
  input  logic                                                      si_id,
  output logic                                                      so_id
);

  localparam int NPE    = NUM_OF_ROWS * NUM_OF_COLS;
  localparam int IDW    = ROW_TAG_WIDTH + COL_TAG_WIDTH;
  localparam int SCAN_W = NPE * IDW;
  localparam int PTR_W  = $clog2(NPE);

  tag_t                           tag_wr;
  tag_t                           tag_head;
  logic                           tags_empty;
  logic                           tag_pop;
  logic                           data_full;
  logic [SCAN_W-1:0]              id_chain;
  logic [NPE-1:0]                 ready_flat;
  logic [NPE-1:0][DATA_WIDTH-1:0] data_flat;
  logic [NPE-1:0]                 req;
  logic [NPE-1:0]                 enable_flat;
  logic                           can_serve;
  logic                           row_any;
  logic                           col_any;
  logic                           grant_valid;
  logic [PTR_W-1:0]               grant_idx;
  logic [PTR_W-1:0]               rr_ptr;
  logic [LEN_WIDTH-1:0]           beat_cnt;
  logic                           last_beat;

  assign ready_flat = ready_in;
  assign data_flat  = data_in;

  assign tag_wr = '{row: row_tag, col: col_tag, len: len_tag};

  sync_fifo #(
    .WIDTH($bits(tag_t)),
    .DEPTH(TAGS_FIFO_DEPTH)
  ) u_tags_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tags_wr_en),
    .wr_data (tag_wr),
    .full    (tags_full),
    .rd_en   (tag_pop),
    .rd_data (tag_head),
    .empty   (tags_empty)
  );

  sync_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(DATA_FIFO_DEPTH)
  ) u_data_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (grant_valid),
    .wr_data (data_flat[grant_idx]),
    .full    (data_full),
    .rd_en   (data_rd_en),
    .rd_data (data_out),
    .empty   (data_empty)
  );

  // ID scan chain: si_id enters at bit 0, so_id leaves from the top bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_chain <= '0;
    end else if (se_id) begin
      id_chain <= {id_chain[SCAN_W-2:0], si_id};
    end
  end

  assign so_id = id_chain[SCAN_W-1];

  // Service is frozen while IDs are shifting, and a pop in this cycle does not
  // make room for this cycle's capture.
  assign can_serve = ~tags_empty & ~data_full & ~se_id;
  assign row_any   = (tag_head.row == ROW_ANY);
  assign col_any   = (tag_head.col == COL_ANY);

  for (genvar k = 0; k < NPE; k++) begin : g_match
    logic [ROW_TAG_WIDTH-1:0] row_id;
    logic [COL_TAG_WIDTH-1:0] col_id;
    assign col_id = id_chain[k*IDW +: COL_TAG_WIDTH];
    assign row_id = id_chain[k*IDW+COL_TAG_WIDTH +: ROW_TAG_WIDTH];
    assign req[k] = can_serve & ready_flat[k]
                  & (row_any | (row_id == tag_head.row))
                  & (col_any | (col_id == tag_head.col));
  end

  // Round-robin search starting just after the last granted source.
  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 1; i <= NPE; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NPE) cand = cand - NPE;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  // One-hot pop strobe to the granted PE.
  always_comb begin
    enable_flat = '0;
    if (grant_valid) enable_flat[grant_idx] = 1'b1;
  end

  assign enable_out = enable_flat;

  // The head tag retires on the grant that delivers its final word.
  assign last_beat = grant_valid && (beat_cnt == tag_head.len);
  assign tag_pop   = last_beat;

  // Arbiter pointer and burst beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= PTR_W'(NPE - 1);
      beat_cnt <= '0;
    end else if (grant_valid) begin
      rr_ptr   <= grant_idx;
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_gon_rr_collector.sv
// Self-checking bench for gon_rr_collector: randomized and directed stimulus,
// a queue-based reference model and a negedge monitor acting as scoreboard.
module tb_gon_rr_collector;

  localparam int DW  = 64;
  localparam int RW  = 4;
  localparam int CW  = 4;
  localparam int LW  = 4;
  localparam int R   = 12;
  localparam int C   = 14;
  localparam int N   = R * C;
  localparam int IDW = RW + CW;
  localparam int L   = N * IDW;
  localparam int DFD = 16;
  localparam int TFD = 16;

  typedef struct { int row; int col; int len; } tb_tag_t;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [RW-1:0]              row_tag;
  logic [CW-1:0]              col_tag;
  logic [LW-1:0]              len_tag;
  logic                       tags_wr_en;
  logic                       tags_full;
  logic [R-1:0][C-1:0]        ready_in;
  logic [R-1:0][C-1:0][DW-1:0] data_in;
  logic [R-1:0][C-1:0]        enable_out;
  logic [DW-1:0]              data_out;
  logic                       data_rd_en;
  logic                       data_empty;
  logic                       se_id;
  logic                       si_id;
  logic                       so_id;
  logic [N-1:0]               en_flat;

  assign en_flat = enable_out;

  gon_rr_collector dut (
    .clk        (clk),
    .reset      (reset),
    .row_tag    (row_tag),
    .col_tag    (col_tag),
    .len_tag    (len_tag),
    .tags_wr_en (tags_wr_en),
    .tags_full  (tags_full),
    .ready_in   (ready_in),
    .data_in    (data_in),
    .enable_out (enable_out),
    .data_out   (data_out),
    .data_rd_en (data_rd_en),
    .data_empty (data_empty),
    .se_id      (se_id),
    .si_id      (si_id),
    .so_id      (so_id)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  tb_tag_t     tagq[$];
  logic [DW-1:0] dataq[$];
  int          grant_log[$];
  logic [L-1:0] chain;
  int          last_grant;
  int          beats;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pe_match(input int k, input tb_tag_t t);
    int rid;
    int cid;
    rid = int'(chain[k*IDW+CW +: RW]);
    cid = int'(chain[k*IDW +: CW]);
    return ((t.row == 15) || (rid == t.row)) && ((t.col == 15) || (cid == t.col));
  endfunction

  // Monitor / scoreboard: compares the DUT against the model for the coming edge.
  always @(negedge clk) begin
    int exp_k;
    int dut_k;
    int k;
    tb_tag_t t;
    if (!reset) begin
      check("so_id", so_id, chain[L-1]);
      check("data_empty", data_empty, dataq.size() == 0);
      check("tags_full", tags_full, tagq.size() == TFD);
      check("enable_onehot", $countones(en_flat) <= 1, 1);
      exp_k = -1;
      if (tagq.size() > 0 && dataq.size() < DFD && !se_id) begin
        for (int i = 1; i <= N; i++) begin
          k = (last_grant + i) % N;
          if (exp_k < 0 && ready_in[k/C][k%C] && pe_match(k, tagq[0])) exp_k = k;
        end
      end
      dut_k = -1;
      for (int i = 0; i < N; i++) if (dut_k < 0 && en_flat[i]) dut_k = i;
      check("grant", dut_k, exp_k);
      if (dut_k >= 0) grant_log.push_back(dut_k);
      if (data_rd_en && dataq.size() > 0) begin
        check("data_out", data_out, dataq[0]);
        void'(dataq.pop_front());
      end
      if (exp_k >= 0) begin
        dataq.push_back(data_in[exp_k/C][exp_k%C]);
        last_grant = exp_k;
        beats++;
        if (beats == tagq[0].len + 1) begin
          void'(tagq.pop_front());
          beats = 0;
        end
      end
      if (tags_wr_en && tagq.size() < TFD) begin
        t.row = int'(row_tag);
        t.col = int'(col_tag);
        t.len = int'(len_tag);
        tagq.push_back(t);
      end
      if (se_id) chain = {chain[L-2:0], si_id};
    end
  end

  task automatic rand_data();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        data_in[r][c] = {$urandom(), $urandom()};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rand_data();
  endtask

  // Asserts reset at the current time, checks the cleared outputs at once,
  // then releases reset just after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_data_empty", data_empty, 1);
    check("rst_tags_full", tags_full, 0);
    check("rst_enable_zero", en_flat == '0, 1);
    check("rst_so_id", so_id, 0);
    check("rst_data_out", data_out, 0);
    tagq.delete();
    dataq.delete();
    grant_log.delete();
    chain      = '0;
    last_grant = N - 1;
    beats      = 0;
    tags_wr_en = 1'b0;
    data_rd_en = 1'b0;
    se_id      = 1'b0;
    si_id      = 1'b0;
    ready_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic scan_in(input logic [L-1:0] pat);
    se_id = 1'b1;
    for (int i = L - 1; i >= 0; i--) begin
      si_id = pat[i];
      step();
    end
    se_id = 1'b0;
    si_id = 1'b0;
  endtask

  function automatic logic [L-1:0] coord_pattern(input bit row_only);
    logic [L-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) begin
      p[k*IDW+CW +: RW] = RW'(k / C);
      p[k*IDW +: CW]    = row_only ? '0 : CW'(k % C);
    end
    return p;
  endfunction

  task automatic push_tag(input int r, input int c, input int len);
    row_tag    = RW'(r);
    col_tag    = CW'(c);
    len_tag    = LW'(len);
    tags_wr_en = 1'b1;
    step();
    tags_wr_en = 1'b0;
  endtask

  task automatic wait_grants(input string name, input int n, input int budget);
    int cnt;
    cnt = 0;
    while (grant_log.size() < n && cnt < budget) begin
      step();
      cnt++;
    end
    check(name, grant_log.size() >= n, 1);
  endtask

  task automatic drain(input string name, input int budget);
    int cnt;
    cnt = 0;
    tags_wr_en = 1'b0;
    data_rd_en = 1'b1;
    while ((tagq.size() > 0 || dataq.size() > 0) && cnt < budget) begin
      step();
      cnt++;
    end
    data_rd_en = 1'b0;
    check(name, cnt < budget, 1);
    check({name, "_empty"}, data_empty, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L-1:0] pat;
    int exp2[4];
    int zero_bad;
    reset      = 1'b1;
    row_tag    = '0;
    col_tag    = '0;
    len_tag    = '0;
    tags_wr_en = 1'b0;
    ready_in   = '0;
    data_rd_en = 1'b0;
    se_id      = 1'b0;
    si_id      = 1'b0;
    rand_data();
    #2;
    do_reset();

    // 1: single PE burst of three words.
    scan_in(coord_pattern(0));
    ready_in[2][3] = 1'b1;
    push_tag(2, 3, 2);
    wait_grants("t1_wait", 3, 20);
    repeat (3) step();
    check("t1_count", grant_log.size(), 3);
    for (int i = 0; i < 3; i++) check("t1_grant_pe", grant_log[i], 2 * C + 3);
    drain("t1_drain", 50);

    // 2: wildcard row, round-robin over three PEs.
    do_reset();
    scan_in(coord_pattern(1));
    ready_in[0][0] = 1'b1;
    ready_in[5][0] = 1'b1;
    ready_in[9][0] = 1'b1;
    push_tag(15, 0, 3);
    wait_grants("t2_wait", 4, 30);
    exp2 = '{0, 70, 126, 0};
    for (int i = 0; i < 4; i++)
      check("t2_rr_order", (i < grant_log.size()) ? grant_log[i] : -1, exp2[i]);
    drain("t2_drain", 50);

    // 3: output FIFO back-pressure.
    do_reset();
    ready_in[0][5] = 1'b1;
    push_tag(15, 15, 15);
    push_tag(15, 15, 15);
    wait_grants("t3_fill", 16, 40);
    repeat (5) step();
    check("t3_full_blocks", grant_log.size(), 16);
    check("t3_not_empty", data_empty, 0);
    data_rd_en = 1'b1;
    step();
    data_rd_en = 1'b0;
    check("t3_pop_no_same_cycle", grant_log.size(), 16);
    step();
    check("t3_one_resumed", grant_log.size(), 17);
    repeat (3) step();
    check("t3_full_again", grant_log.size(), 17);
    drain("t3_drain", 100);

    // 4: tag FIFO overflow and push/pop while full.
    do_reset();
    row_tag    = '0;
    col_tag    = '0;
    len_tag    = '0;
    tags_wr_en = 1'b1;
    repeat (17) step();
    tags_wr_en = 1'b0;
    check("t4_full", tags_full, 1);
    ready_in[0][0] = 1'b1;
    tags_wr_en     = 1'b1;
    step();
    ready_in   = '0;
    tags_wr_en = 1'b0;
    check("t4_still_full", tags_full, 1);
    check("t4_one_grant", grant_log.size(), 1);
    ready_in[0][0] = 1'b1;
    drain("t4_drain", 100);
    check("t4_total_grants", grant_log.size(), 17);

    // 5: reset in the middle of a burst, then IDs read back as zero.
    do_reset();
    push_tag(0, 0, 3);
    ready_in[0][0] = 1'b1;
    step();
    ready_in = '0;
    check("t5_one_beat", grant_log.size(), 1);
    ready_in = '1;
    #1;
    check("t5_busy_before_reset", en_flat != '0, 1);
    do_reset();
    se_id    = 1'b1;
    si_id    = 1'b0;
    zero_bad = 0;
    for (int i = 0; i < L; i++) begin
      if (so_id !== 1'b0) zero_bad++;
      step();
    end
    se_id = 1'b0;
    check("t5_ids_zero", zero_bad, 0);

    // 6: scan enable blocks service; scan pattern round trip.
    do_reset();
    push_tag(0, 0, 0);
    se_id          = 1'b1;
    si_id          = 1'b0;
    ready_in[0][0] = 1'b1;
    repeat (20) step();
    check("t6_no_grant_in_scan", grant_log.size(), 0);
    ready_in = '0;
    for (int i = 0; i < L; i++) pat[i] = 1'($urandom_range(0, 1));
    scan_in(pat);
    se_id = 1'b1;
    zero_bad = 0;
    for (int i = L - 1; i >= 0; i--) begin
      if (so_id !== pat[i]) zero_bad++;
      step();
    end
    se_id = 1'b0;
    check("t6_pattern_roundtrip", zero_bad, 0);

    // Randomized traffic against the reference model.
    do_reset();
    scan_in(coord_pattern(0));
    for (int cyc = 0; cyc < 2500; cyc++) begin
      tags_wr_en = ($urandom_range(0, 3) == 0);
      row_tag    = ($urandom_range(0, 3) == 0) ? '1 : RW'($urandom_range(0, R - 1));
      col_tag    = ($urandom_range(0, 3) == 0) ? '1 : CW'($urandom_range(0, C - 1));
      len_tag    = LW'($urandom_range(0, 3));
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          ready_in[r][c] = 1'($urandom_range(0, 1));
      data_rd_en = 1'($urandom_range(0, 1));
      step();
    end
    ready_in = '1;
    drain("rand_drain", 3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
